cc_bus_select_arbiter: RTL and testbench

Registered, arbitrated bus-source selector; the successor of the combinational register/control bus mux.
- Accepts a channel request from the control unit and one from the instruction register field.
- Arbitrates between them with alternating priority and latches the winning channel index for a minimum hold time.
- Drives the datapath bus-select lines until the owner releases.
- Flags out-of-range channel requests.

---
 rtl/cc_bus_select_arbiter.sv | 135 +++++++++++++
 tb/tb_cc_bus_select_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_bus_select_arbiter.sv
// rtl/cc_bus_select_arbiter.sv - registered alternating-priority bus-source arbiter
// Optional watchdog enabled by defining CC_BUSSEL_TIMEOUT_EN.
module cc_bus_select_arbiter #(
    parameter int DATAWIDTH_SEL_CONTROL = 6,
    parameter int DATAWIDTH_SEL_REG     = 5,
    parameter int DATAWIDTH_BUS         = 4,
    parameter int NUM_SOURCES           = 12,
    parameter int HOLD_CYCLES           = 2,
    parameter int TIMEOUT_CYCLES        = 16
) (
    input  logic                             CC_BUSSEL_CLOCK_50,
    input  logic                             CC_BUSSEL_RESET_InHigh,
    input  logic [DATAWIDTH_SEL_CONTROL-1:0] CC_BUSSEL_control_InBUS,
    input  logic                             CC_BUSSEL_control_req_In,
    input  logic [DATAWIDTH_SEL_REG-1:0]     CC_BUSSEL_registro_InBUS,
    input  logic                             CC_BUSSEL_registro_req_In,
    input  logic                             CC_BUSSEL_release_In,
    output logic [DATAWIDTH_BUS-1:0]         CC_BUSSEL_data_OutBUS,
    output logic                             CC_BUSSEL_valid_Out,
    output logic                             CC_BUSSEL_owner_Out,
    output logic                             CC_BUSSEL_error_Out,
    output logic                             CC_BUSSEL_timeout_Out
);
    localparam int IDXW = (DATAWIDTH_SEL_CONTROL > DATAWIDTH_SEL_REG) ?
                          DATAWIDTH_SEL_CONTROL : DATAWIDTH_SEL_REG;
    localparam int HW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    if (NUM_SOURCES > (1 << DATAWIDTH_BUS) || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1)
        $error("cc_bus_select_arbiter: illegal parameter combination");

    logic [0:0]               r_state;
    logic [HW-1:0]            r_hold;
    logic                     r_last_owner;
    logic [DATAWIDTH_BUS-1:0] r_data;
    logic                     r_valid;
    logic                     r_owner;
    logic                     r_error;

    logic                     w_force;
    logic                     w_honour;
    logic                     w_do_grant;
    logic                     w_win;
    logic [IDXW-1:0]          w_idx;
    logic                     w_oob;

`ifdef CC_BUSSEL_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] r_wdog;
    logic          r_timeout;
    assign w_force = (32'(r_wdog) == TIMEOUT_CYCLES - 1);
    assign CC_BUSSEL_timeout_Out = r_timeout;
`else
    assign w_force = 1'b0;
    assign CC_BUSSEL_timeout_Out = 1'b0;
`endif

    // Owner bit doubles as requester id: 0 = control unit, 1 = register field.
    always_comb begin
        w_do_grant = 1'b0;
        w_win      = 1'b0;
        w_honour   = (r_state == ST_GRANT) &&
                     (((r_hold == '0) && CC_BUSSEL_release_In) || w_force);
        if (r_state == ST_IDLE) begin
            if (CC_BUSSEL_control_req_In && CC_BUSSEL_registro_req_In) begin
                w_do_grant = 1'b1;
                w_win      = ~r_last_owner;
            end else if (CC_BUSSEL_control_req_In || CC_BUSSEL_registro_req_In) begin
                w_do_grant = 1'b1;
                w_win      = CC_BUSSEL_registro_req_In;
            end
        end else if (w_honour) begin
            if (r_owner ? CC_BUSSEL_control_req_In : CC_BUSSEL_registro_req_In) begin
                w_do_grant = 1'b1;
                w_win      = ~r_owner;
            end else if (r_owner ? CC_BUSSEL_registro_req_In : CC_BUSSEL_control_req_In) begin
                w_do_grant = 1'b1;
                w_win      = r_owner;
            end
        end
        w_idx = w_win ? IDXW'(CC_BUSSEL_registro_InBUS) : IDXW'(CC_BUSSEL_control_InBUS);
        w_oob = (32'(w_idx) >= NUM_SOURCES);
    end

    always_ff @(posedge CC_BUSSEL_CLOCK_50) begin
        if (CC_BUSSEL_RESET_InHigh) begin
            r_state      <= ST_IDLE;
            r_hold       <= '0;
            r_last_owner <= 1'b1;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_owner      <= 1'b0;
            r_error      <= 1'b0;
`ifdef CC_BUSSEL_TIMEOUT_EN
            r_wdog       <= '0;
            r_timeout    <= 1'b0;
`endif
        end else if (w_do_grant) begin
            r_state      <= ST_GRANT;
            r_hold       <= HW'(HOLD_CYCLES - 1);
            r_last_owner <= w_win;
            r_owner      <= w_win;
            r_valid      <= 1'b1;
            r_data       <= w_oob ? '0 : w_idx[DATAWIDTH_BUS-1:0];
            if (w_oob)
                r_error <= 1'b1;
`ifdef CC_BUSSEL_TIMEOUT_EN
            r_wdog       <= '0;
            r_timeout    <= (TIMEOUT_CYCLES == 1);
`endif
        end else if (w_honour) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
`ifdef CC_BUSSEL_TIMEOUT_EN
            r_wdog    <= '0;
            r_timeout <= 1'b0;
`endif
        end else if (r_state == ST_GRANT) begin
            if (r_hold != '0)
                r_hold <= r_hold - 1'b1;
`ifdef CC_BUSSEL_TIMEOUT_EN
            // Pulse is raised for the cycle in which the forced release will take effect.
            r_wdog    <= r_wdog + 1'b1;
            r_timeout <= (32'(r_wdog) + 1 == TIMEOUT_CYCLES - 1);
`endif
        end
    end

    assign CC_BUSSEL_data_OutBUS = r_data;
    assign CC_BUSSEL_valid_Out   = r_valid;
    assign CC_BUSSEL_owner_Out   = r_owner;
    assign CC_BUSSEL_error_Out   = r_error;
endmodule

// File: tb/tb_cc_bus_select_arbiter.sv
// tb/tb_cc_bus_select_arbiter.sv - self-checking bench for cc_bus_select_arbiter
module tb_cc_bus_select_arbiter;
    localparam int NUM     = 12;
    localparam int HOLD    = 2;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] cidx = '0;
    logic       creq = 1'b0;
    logic [4:0] ridx = '0;
    logic       rreq = 1'b0;
    logic       rel  = 1'b0;
    logic [3:0] dout;
    logic       valid, owner, err, tmo;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: age counts edges spent in the current grant.
    logic       m_valid, m_owner, m_error, m_timeout, m_last;
    logic [3:0] m_data;
    int         m_age;

    cc_bus_select_arbiter dut (
        .CC_BUSSEL_CLOCK_50       (clk),
        .CC_BUSSEL_RESET_InHigh   (rst),
        .CC_BUSSEL_control_InBUS  (cidx),
        .CC_BUSSEL_control_req_In (creq),
        .CC_BUSSEL_registro_InBUS (ridx),
        .CC_BUSSEL_registro_req_In(rreq),
        .CC_BUSSEL_release_In     (rel),
        .CC_BUSSEL_data_OutBUS    (dout),
        .CC_BUSSEL_valid_Out      (valid),
        .CC_BUSSEL_owner_Out      (owner),
        .CC_BUSSEL_error_Out      (err),
        .CC_BUSSEL_timeout_Out    (tmo)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        int         win;
        logic       honour;
        logic [5:0] idx;
        if (rst) begin
            m_valid = 0; m_data = 0; m_owner = 0; m_error = 0;
            m_timeout = 0; m_last = 1; m_age = 0;
            return;
        end
        win = -1;
        if (!m_valid) begin
            if (creq && rreq) win = m_last ? 0 : 1;
            else if (creq)    win = 0;
            else if (rreq)    win = 1;
        end else begin
            honour = rel && (m_age >= HOLD - 1);
`ifdef CC_BUSSEL_TIMEOUT_EN
            if (m_age == TIMEOUT - 1) honour = 1'b1;
`endif
            if (honour) begin
                if (m_owner ? creq : rreq)      win = m_owner ? 0 : 1;
                else if (m_owner ? rreq : creq) win = m_owner ? 1 : 0;
                else begin m_valid = 0; m_data = 0; end
            end else begin
                m_age++;
            end
        end
        if (win >= 0) begin
            idx = (win == 1) ? {1'b0, ridx} : cidx;
            m_valid = 1; m_owner = (win == 1); m_last = (win == 1); m_age = 0;
            if (int'(idx) >= NUM) begin m_data = 0; m_error = 1; end
            else m_data = idx[3:0];
        end
        m_timeout = 0;
`ifdef CC_BUSSEL_TIMEOUT_EN
        m_timeout = m_valid && (m_age == TIMEOUT - 1);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1; creq = 0; rreq = 0; rel = 0;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; creq = 1; rreq = 1; cidx = 6'd3; ridx = 5'd9; rel = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({valid, dout, owner, err, tmo} !== 8'd0) begin
                n_err++;
                $display("FAIL reset_outputs cyc=%0d got=%b exp=0", i, {valid, dout, owner, err, tmo});
            end
        end
        rst = 0;
        tick();
        n_cmp++;
        if (valid !== 1'b1 || owner !== 1'b0 || dout !== 4'd3) begin
            n_err++;
            $display("FAIL reset_first_tie got v=%0d o=%0d d=%0d exp v=1 o=0 d=3", valid, owner, dout);
        end
    endtask

    task automatic test_single_hold();
        do_reset();
        creq = 1; cidx = 6'd5;
        tick();
        n_cmp++;
        if (valid !== 1'b1 || dout !== 4'd5 || owner !== 1'b0) begin
            n_err++;
            $display("FAIL single_grant got v=%0d d=%0d o=%0d exp v=1 d=5 o=0", valid, dout, owner);
        end
        creq = 0; rel = 1;
        tick();
        n_cmp++;
        if (valid !== 1'b1 || dout !== 4'd5) begin
            n_err++;
            $display("FAIL hold_ignores_release got v=%0d d=%0d exp v=1 d=5", valid, dout);
        end
        tick();
        n_cmp++;
        if (valid !== 1'b0 || dout !== 4'd0) begin
            n_err++;
            $display("FAIL release_to_idle got v=%0d d=%0d exp v=0 d=0", valid, dout);
        end
        rel = 0;
    endtask

    task automatic test_alternate();
        logic [3:0] exp_d [5] = '{4'd3, 4'd3, 4'd9, 4'd9, 4'd3};
        logic       exp_o [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        creq = 1; rreq = 1; cidx = 6'd3; ridx = 5'd9; rel = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (valid !== 1'b1 || dout !== exp_d[i] || owner !== exp_o[i]) begin
                n_err++;
                $display("FAIL alternate step=%0d got v=%0d d=%0d o=%0d exp v=1 d=%0d o=%0d",
                         i, valid, dout, owner, exp_d[i], exp_o[i]);
            end
        end
        creq = 0; rreq = 0; rel = 0;
    endtask

    task automatic test_range_error();
        do_reset();
        creq = 1; cidx = 6'd11;
        tick();
        n_cmp++;
        if (dout !== 4'd11 || err !== 1'b0) begin
            n_err++;
            $display("FAIL range_top_valid got d=%0d e=%0d exp d=11 e=0", dout, err);
        end
        do_reset();
        rreq = 1; ridx = 5'd13;
        tick();
        n_cmp++;
        if (valid !== 1'b1 || dout !== 4'd0 || owner !== 1'b1 || err !== 1'b1) begin
            n_err++;
            $display("FAIL oob_grant got v=%0d d=%0d o=%0d e=%0d exp v=1 d=0 o=1 e=1", valid, dout, owner, err);
        end
        rreq = 0; rel = 1;
        tick(); tick();
        rel = 0; creq = 1; cidx = 6'd2;
        tick();
        n_cmp++;
        if (valid !== 1'b1 || dout !== 4'd2 || err !== 1'b1) begin
            n_err++;
            $display("FAIL error_sticky got v=%0d d=%0d e=%0d exp v=1 d=2 e=1", valid, dout, err);
        end
        rst = 1;
        tick();
        rst = 0; creq = 0;
        n_cmp++;
        if (err !== 1'b0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL error_reset_clear got e=%0d v=%0d exp e=0 v=0", err, valid);
        end
    endtask

    task automatic test_frozen();
        int bad = 0;
        do_reset();
        creq = 1; cidx = 6'd5;
        tick();
        cidx = 6'd7; ridx = 5'd4;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (dout !== 4'd5 || valid !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL frozen_data bad_cycles=%0d exp 0 (last d=%0d)", bad, dout);
        end
        creq = 0; rel = 1;
        tick();
        n_cmp++;
        if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL frozen_release got v=%0d exp v=0", valid);
        end
        rel = 0;
    endtask

`ifdef CC_BUSSEL_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        creq = 1; cidx = 6'd6;
        tick();
        creq = 0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            n_cmp++;
            if (valid !== 1'b1 || tmo !== (k == TIMEOUT)) begin
                n_err++;
                $display("FAIL timeout_cycle k=%0d got v=%0d t=%0d exp v=1 t=%0d", k, valid, tmo, k == TIMEOUT);
            end
            tick();
        end
        n_cmp++;
        if (valid !== 1'b0 || tmo !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_release got v=%0d t=%0d exp v=0 t=0", valid, tmo);
        end
    endtask
`else
    task automatic test_hold_forever();
        int bad = 0;
        do_reset();
        creq = 1; cidx = 6'd4;
        tick();
        creq = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (valid !== 1'b1 || tmo !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL hold_forever bad_cycles=%0d exp 0", bad);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 59) == 0);
            creq = $urandom_range(0, 1);
            rreq = $urandom_range(0, 1);
            cidx = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 14));
            ridx = 5'($urandom_range(0, 31));
            rel  = ($urandom_range(0, 2) == 0);
            tick();
            n_cmp++;
            if (valid !== m_valid || dout !== m_data || owner !== m_owner ||
                err !== m_error || tmo !== m_timeout) begin
                n_err++;
                $display("FAIL random cyc=%0d got v=%0d d=%0d o=%0d e=%0d t=%0d exp v=%0d d=%0d o=%0d e=%0d t=%0d",
                         i, valid, dout, owner, err, tmo, m_valid, m_data, m_owner, m_error, m_timeout);
            end
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_single_hold();
        test_alternate();
        test_range_error();
        test_frozen();
`ifdef CC_BUSSEL_TIMEOUT_EN
        test_timeout();
`else
        test_hold_forever();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
